// File: rtl/load_store_unit.sv
// Load/store unit: byte-addressed CPU requests to a word-addressed data memory.
// Optional LSU_RANGE_CHECK_EN additionally rejects addresses outside BASE_WORD..TOP_WORD.
module load_store_unit #(
  parameter int          ADDR_W    = 11,
  parameter int unsigned BASE_WORD = 32'd1024,
  parameter int unsigned TOP_WORD  = 32'd2047
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              op_write,
  input  logic [1:0]        op_size,
  input  logic              op_signed,
  input  logic [31:0]       vaddr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              addr_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_RMW_RD = 3'd2,
    S_WRITE  = 3'd3,
    S_RESP   = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          op_size_q;
  logic                op_signed_q;
  logic [1:0]          lane_q;
  logic [15:0]         wdata_q;
  logic                err_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [31:0]         mem_wdata_q;
  logic [31:0]         rdata_q;

  logic [31:0]         word_full_s;
  logic                range_err_s;
  logic                req_err_s;

  function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] lane);
    logic r;
    case (size)
      2'b00:   r = 1'b0;
      2'b01:   r = lane[0];
      2'b10:   r = (lane != 2'b00);
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] lsu_extract(input logic [31:0] w, input logic [1:0] size,
                                              input logic [1:0] lane, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lane)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = lane[1] ? w[31:16] : w[15:0];
    case (size)
      2'b00:   r = sgn ? {{24{b[7]}}, b} : {24'h000000, b};
      2'b01:   r = sgn ? {{16{h[15]}}, h} : {16'h0000, h};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] lsu_merge(input logic [31:0] w, input logic [15:0] wd,
                                            input logic [1:0] size, input logic [1:0] lane);
    logic [31:0] r;
    r = w;
    case (size)
      2'b00: begin
        case (lane)
          2'd0:    r[7:0]   = wd[7:0];
          2'd1:    r[15:8]  = wd[7:0];
          2'd2:    r[23:16] = wd[7:0];
          default: r[31:24] = wd[7:0];
        endcase
      end
      2'b01: begin
        if (lane[1]) r[31:16] = wd;
        else         r[15:0]  = wd;
      end
      default: r = w;
    endcase
    return r;
  endfunction

  // Request validity: alignment always, address range only when the check is built in.
  always_comb begin
    word_full_s = {2'b00, vaddr[31:2]};
    range_err_s = (vaddr[31:ADDR_W+2] != '0) || (word_full_s < BASE_WORD) || (word_full_s > TOP_WORD);
`ifdef LSU_RANGE_CHECK_EN
    req_err_s = lsu_misaligned(op_size, vaddr[1:0]) || range_err_s;
`else
    req_err_s = lsu_misaligned(op_size, vaddr[1:0]);
`endif
  end

`ifndef LSU_RANGE_CHECK_EN
  logic unused_range_s;
  assign unused_range_s = range_err_s;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; IDLE and RESP both accept a new request.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_RESP: begin
        if (req) begin
          if (req_err_s)              state_d = S_RESP;
          else if (!op_write)         state_d = S_LOAD;
          else if (op_size == 2'b10)  state_d = S_WRITE;
          else                        state_d = S_RMW_RD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD:   state_d = S_RESP;
      S_RMW_RD: state_d = S_WRITE;
      S_WRITE:  state_d = S_RESP;
      default:  state_d = S_IDLE;
    endcase
  end

  // Operation fields, load result and store word.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_size_q   <= 2'b00;
      op_signed_q <= 1'b0;
      lane_q      <= 2'b00;
      wdata_q     <= 16'h0000;
      err_q       <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'h00000000;
      rdata_q     <= 32'h00000000;
    end else begin
      case (state_q)
        S_IDLE, S_RESP: begin
          if (req) begin
            op_size_q   <= op_size;
            op_signed_q <= op_signed;
            lane_q      <= vaddr[1:0];
            wdata_q     <= wdata[15:0];
            err_q       <= req_err_s;
            mem_addr_q  <= vaddr[ADDR_W+1:2];
            if (op_write && (op_size == 2'b10) && !req_err_s) mem_wdata_q <= wdata;
          end
        end
        S_LOAD:   rdata_q     <= lsu_extract(mem_rdata, op_size_q, lane_q, op_signed_q);
        S_RMW_RD: mem_wdata_q <= lsu_merge(mem_rdata, wdata_q, op_size_q, lane_q);
        default: ;
      endcase
    end
  end

  // Outputs decoded from the state register; a reset in WRITE kills the write strobe.
  always_comb begin
    busy      = (state_q == S_LOAD) || (state_q == S_RMW_RD) || (state_q == S_WRITE);
    done      = (state_q == S_RESP);
    addr_err  = (state_q == S_RESP) && err_q;
    mem_read  = (state_q == S_LOAD) || (state_q == S_RMW_RD);
    mem_write = (state_q == S_WRITE) && !rst;
  end

  assign rdata     = rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit with a byte-level reference memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        op_write;
  logic [1:0]  op_size;
  logic        op_signed;
  logic [31:0] vaddr;
  logic [31:0] wdata;
  logic        busy, done, addr_err, mem_read, mem_write;
  logic [31:0] rdata, mem_wdata, mem_rdata;
  logic [10:0] mem_addr;

  logic [31:0] dmem    [0:2047];
  logic [31:0] ref_mem [0:2047];
  logic [31:0] last_rdata;
  int          n_checks = 0;
  int          n_fail   = 0;

  load_store_unit dut (
    .clk(clk), .rst(rst), .req(req), .op_write(op_write), .op_size(op_size),
    .op_signed(op_signed), .vaddr(vaddr), .wdata(wdata), .busy(busy), .done(done),
    .rdata(rdata), .addr_err(addr_err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = dmem[mem_addr];
  always @(posedge clk) begin
    if (mem_write) dmem[mem_addr] <= mem_wdata;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one request and follow it to completion, checking against the model.
  task automatic do_op(input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd, input logic pulse);
    logic        exp_err;
    logic [10:0] w;
    logic [31:0] mask, exp_word, exp_rd, tmp;
    int          sh, lat_exp, cyc, rd_cnt, wr_cnt, rd_cyc, wr_cyc, both;
    w = a[12:2];
    exp_err = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
`ifdef LSU_RANGE_CHECK_EN
    if (a[31:13] != 19'd0 || w < 11'd1024) exp_err = 1'b1;
`endif
    mask = (sz == 2'd0) ? 32'h000000FF : (sz == 2'd1) ? 32'h0000FFFF : 32'hFFFFFFFF;
    sh   = 8 * int'(a[1:0]);
    exp_word = ref_mem[w];
    if (wr && !exp_err) exp_word = (exp_word & ~(mask << sh)) | ((wd & mask) << sh);
    tmp = (ref_mem[w] >> sh) & mask;
    if (sg && ((sz == 2'd0 && tmp[7]) || (sz == 2'd1 && tmp[15]))) tmp = tmp | ~mask;
    exp_rd  = (!wr && !exp_err) ? tmp : last_rdata;
    lat_exp = exp_err ? 1 : (!wr || sz == 2'd2) ? 2 : 3;

    req = 1'b1; op_write = wr; op_size = sz; op_signed = sg; vaddr = a; wdata = wd;
    @(posedge clk); #1;
    req = 1'b0;
    cyc = 1; rd_cnt = 0; wr_cnt = 0; rd_cyc = 0; wr_cyc = 0; both = 0;
    while (!done && cyc <= 8) begin
      if (mem_read)  begin rd_cnt++; rd_cyc = cyc; check_eq("rd_addr", 32'(mem_addr), 32'(w)); end
      if (mem_write) begin
        wr_cnt++; wr_cyc = cyc;
        check_eq("wr_addr", 32'(mem_addr), 32'(w));
        check_eq("wr_data", mem_wdata, exp_word);
      end
      if (mem_read && mem_write) both++;
      if (pulse && busy) begin
        req = 1'b1; op_write = 1'($urandom); op_size = 2'($urandom);
        vaddr = $urandom; wdata = $urandom;
      end else begin
        req = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    req = 1'b0;
    if (!done) begin
      check_eq("timeout", 32'(done), 32'd1);
      return;
    end
    if (mem_read)  rd_cnt++;
    if (mem_write) wr_cnt++;
    check_eq("latency",  32'(cyc), 32'(lat_exp));
    check_eq("addr_err", 32'(addr_err), 32'(exp_err));
    check_eq("rd_cnt",   32'(rd_cnt), (exp_err || (wr && sz == 2'd2)) ? 32'd0 : 32'd1);
    check_eq("wr_cnt",   32'(wr_cnt), (wr && !exp_err) ? 32'd1 : 32'd0);
    check_eq("rd_cyc",   32'(rd_cyc), (exp_err || (wr && sz == 2'd2)) ? 32'd0 : 32'd1);
    check_eq("wr_cyc",   32'(wr_cyc), (!wr || exp_err) ? 32'd0 : (sz == 2'd2) ? 32'd1 : 32'd2);
    check_eq("rd_wr_excl", 32'(both), 32'd0);
    check_eq("rdata",    rdata, exp_rd);
    check_eq("mem_word", dmem[w], exp_word);
    ref_mem[w] = exp_word;
    last_rdata = exp_rd;
  endtask

  initial begin
    logic [31:0] a, wd;
    logic [1:0]  sz;
    int          r;
    logic        pulse;

    for (int i = 0; i < 2048; i++) begin
      dmem[i]    = $urandom;
      ref_mem[i] = dmem[i];
    end
    last_rdata = 32'h0;

    // Reset held with a pending request.
    rst = 1'b1; req = 1'b1; op_write = 1'b0; op_size = 2'd2; op_signed = 1'b0;
    vaddr = 32'h00001004; wdata = 32'h0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_done", 32'(done), 32'd0);
      check_eq("rst_rdata", rdata, 32'd0);
      check_eq("rst_mrd", 32'(mem_read), 32'd0);
      check_eq("rst_mwr", 32'(mem_write), 32'd0);
    end
    rst = 1'b0; req = 1'b0;
    @(posedge clk); #1;
    check_eq("post_rst_busy", 32'(busy), 32'd0);
    check_eq("post_rst_done", 32'(done), 32'd0);

    // sw / lw round trip, then sb read-modify-write.
    do_op(1'b1, 2'd2, 1'b0, 32'h00001004, 32'hDEADBEEF, 1'b0);
    do_op(1'b0, 2'd2, 1'b0, 32'h00001004, 32'h0, 1'b0);
    check_eq("lw_val", rdata, 32'hDEADBEEF);
    do_op(1'b1, 2'd0, 1'b0, 32'h00001005, 32'h000000A5, 1'b0);
    check_eq("sb_merge", dmem[11'h401], 32'hDEADA5EF);

    // Sign and zero extension.
    do_op(1'b1, 2'd2, 1'b0, 32'h00001004, 32'h80FF1234, 1'b0);
    do_op(1'b0, 2'd0, 1'b1, 32'h00001007, 32'h0, 1'b0);
    check_eq("lb", rdata, 32'hFFFFFF80);
    do_op(1'b0, 2'd0, 1'b0, 32'h00001007, 32'h0, 1'b0);
    check_eq("lbu", rdata, 32'h00000080);
    do_op(1'b0, 2'd1, 1'b1, 32'h00001006, 32'h0, 1'b0);
    check_eq("lh", rdata, 32'hFFFF80FF);
    do_op(1'b0, 2'd1, 1'b0, 32'h00001006, 32'h0, 1'b0);
    check_eq("lhu", rdata, 32'h000080FF);

    // Misaligned, low address, request while busy.
    do_op(1'b0, 2'd2, 1'b0, 32'h00001002, 32'h0, 1'b0);
    do_op(1'b0, 2'd2, 1'b0, 32'h00000FFC, 32'h0, 1'b0);
    do_op(1'b0, 2'd2, 1'b0, 32'h00001008, 32'h0, 1'b1);
    @(posedge clk); #1;
    check_eq("busy_req_ignored", 32'({busy, done}), 32'd0);

    // Reset during the WRITE cycle of an sh.
    req = 1'b1; op_write = 1'b1; op_size = 2'd1; op_signed = 1'b0;
    vaddr = 32'h00001004; wdata = 32'h0000BEEF;
    @(posedge clk); #1;
    req = 1'b0;
    check_eq("sh_rmw_read", 32'(mem_read), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_eq("sh_rst_mwr", 32'(mem_write), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("sh_rst_idle", 32'({busy, done}), 32'd0);
    check_eq("sh_rst_word", dmem[11'h401], 32'h80FF1234);
    last_rdata = 32'h0;
    do_op(1'b0, 2'd2, 1'b0, 32'h00001004, 32'h0, 1'b0);

    // Randomized traffic, back-to-back and with gaps.
    for (int n = 0; n < 400; n++) begin
      r  = int'($urandom_range(9, 0));
      sz = (r < 4) ? 2'd0 : (r < 7) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      r  = int'($urandom_range(9, 0));
      if (r == 0)      a = $urandom;
      else if (r == 1) a = {19'd0, $urandom_range(2047, 0), 2'b00};
      else             a = {19'd0, 1'b1, 10'($urandom_range(1023, 0)), 2'b00};
      a[1:0] = 2'($urandom);
      if ($urandom_range(3, 0) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      wd    = $urandom;
      pulse = ($urandom_range(7, 0) == 0);
      do_op(1'($urandom), sz, 1'($urandom), a, wd, pulse);
      if (pulse) begin
        @(posedge clk); #1;
        check_eq("rnd_busy_req", 32'({busy, done}), 32'd0);
      end else if ($urandom_range(2, 0) == 0) begin
        @(posedge clk); #1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
